// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared mode encodings, sequencer states and die index helper
package spi_flash_pkg;
  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_DUAL   = 2'd1;
  localparam logic [1:0] MODE_QUAD   = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_SPACE,
    S_ISSUE,
    S_WAIT_DONE,
    S_DONE,
    S_ERR
  } state_t;
  function automatic logic [2:0] die_of(input logic [63:0] addr, input int die_addr_w);
    return 3'(addr >> die_addr_w);
  endfunction
endpackage

// File: rtl/spi_burst_len_calc.sv
// spi_burst_len_calc: burst length = min(MAX_BURST, remaining, distance to die end, fifo space)
module spi_burst_len_calc #(
  parameter int ADDR_W     = 32,
  parameter int DIE_ADDR_W = 25,
  parameter int MAX_BURST  = 256,
  parameter int LEN_W      = 9,
  parameter int FREE_W     = 10
) (
  input  logic [ADDR_W:0]       remaining,
  input  logic [DIE_ADDR_W-1:0] die_offset,
  input  logic [FREE_W-1:0]     fifo_free,
  output logic [LEN_W-1:0]      len
);
  logic [63:0]      die_dist;
  logic [LEN_W-1:0] rem_c, dist_c, free_c, m1;
  // each operand is saturated to MAX_BURST so the min can run at LEN_W bits
  function automatic logic [LEN_W-1:0] sat(input logic [63:0] x);
    return x > 64'(MAX_BURST) ? LEN_W'(MAX_BURST) : LEN_W'(x);
  endfunction
  always_comb begin
    die_dist = (64'(1) << DIE_ADDR_W) - 64'(die_offset);
    rem_c    = sat(64'(remaining));
    dist_c   = sat(die_dist);
    free_c   = sat(64'(fifo_free));
    m1       = rem_c < dist_c ? rem_c : dist_c;
    len      = m1 < free_c ? m1 : free_c;
  end
endmodule

// File: rtl/spi_flash_burst_reader.sv
// spi_flash_burst_reader: splits an inclusive multi-die byte range into clipped QSPI burst commands
module spi_flash_burst_reader
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DIE_ADDR_W = 25,
  parameter int NUM_DIES   = 2,
  parameter int MAX_BURST  = 256,
  parameter int LEN_W      = 9,
  parameter int FREE_W     = 10
) (
  input  logic                  system_clk,
  input  logic                  system_reset_n,
  input  logic                  start_flag,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  read_finish,
  output logic                  error,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [2:0]            cmd_die,
  output logic [DIE_ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]      cmd_len,
  output logic [1:0]            cmd_mode,
  input  logic                  ctrl_done,
  input  logic [FREE_W-1:0]     fifo_free
);
  localparam logic [ADDR_W:0] DIE_LIMIT = (ADDR_W+1)'(NUM_DIES) << DIE_ADDR_W;
  state_t            state;
  logic [ADDR_W-1:0] curr_addr, end_q;
  logic [ADDR_W:0]   remaining;
  logic              abort_q, bad_req;
  logic [LEN_W-1:0]  burst_len;
  spi_burst_len_calc #(
    .ADDR_W(ADDR_W), .DIE_ADDR_W(DIE_ADDR_W), .MAX_BURST(MAX_BURST),
    .LEN_W(LEN_W), .FREE_W(FREE_W)
  ) u_len (
    .remaining (remaining),
    .die_offset(curr_addr[DIE_ADDR_W-1:0]),
    .fifo_free (fifo_free),
    .len       (burst_len)
  );
  always_comb bad_req = (end_q < curr_addr) || ({1'b0, end_q} >= DIE_LIMIT) || (cmd_mode == MODE_RSVD);
  always_ff @(posedge system_clk) begin
    if (!system_reset_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      read_finish <= 1'b0;
      error       <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_die     <= '0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      cmd_mode    <= '0;
      curr_addr   <= '0;
      end_q       <= '0;
      remaining   <= '0;
      abort_q     <= 1'b0;
    end else begin
      read_finish <= 1'b0;
      error       <= 1'b0;
      case (state)
        S_IDLE: if (start_flag) begin
          curr_addr <= start_addr;
          end_q     <= end_addr;
          cmd_mode  <= mode;
          abort_q   <= 1'b0;
          busy      <= 1'b1;
          state     <= S_CHECK;
        end
        S_CHECK: if (bad_req) begin
          error <= 1'b1;
          state <= S_ERR;
        end else begin
          remaining <= {1'b0, end_q} - {1'b0, curr_addr} + (ADDR_W+1)'(1);
          state     <= S_WAIT_SPACE;
        end
        S_WAIT_SPACE: if (abort) begin
          read_finish <= 1'b1;
          state       <= S_DONE;
        end else if (fifo_free != '0) begin
          cmd_die   <= die_of(64'(curr_addr), DIE_ADDR_W);
          cmd_addr  <= curr_addr[DIE_ADDR_W-1:0];
          cmd_len   <= burst_len;
          cmd_valid <= 1'b1;
          state     <= S_ISSUE;
        end
        S_ISSUE: if (cmd_ready) begin
          cmd_valid <= 1'b0;
          curr_addr <= curr_addr + ADDR_W'(cmd_len);
          remaining <= remaining - (ADDR_W+1)'(cmd_len);
          state     <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (abort) abort_q <= 1'b1;
          if (ctrl_done) begin
            read_finish <= (remaining == '0) || abort || abort_q;
            state       <= ((remaining == '0) || abort || abort_q) ? S_DONE : S_WAIT_SPACE;
          end
        end
        S_DONE, S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_burst_reader.sv
// tb_spi_flash_burst_reader: directed self-checking bench for the burst reader
module tb_spi_flash_burst_reader;
  logic        system_clk = 1'b0;
  logic        system_reset_n = 1'b0;
  logic        start_flag = 1'b0, abort = 1'b0, cmd_ready = 1'b1, ctrl_done = 1'b0;
  logic [31:0] start_addr = '0, end_addr = '0;
  logic [1:0]  mode = '0;
  logic [9:0]  fifo_free = 10'd512;
  logic        busy, read_finish, error, cmd_valid;
  logic [2:0]  cmd_die;
  logic [24:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic [1:0]  cmd_mode;
  int n_cmp = 0, n_err = 0;
  spi_flash_burst_reader dut (
    .system_clk(system_clk), .system_reset_n(system_reset_n),
    .start_flag(start_flag), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr), .mode(mode),
    .busy(busy), .read_finish(read_finish), .error(error),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_die(cmd_die), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_mode(cmd_mode),
    .ctrl_done(ctrl_done), .fifo_free(fifo_free)
  );
  always #5 system_clk = ~system_clk;
  task automatic step();
    @(posedge system_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [31:0] s, input logic [31:0] e, input logic [1:0] m);
    start_addr = s;
    end_addr   = e;
    mode       = m;
    start_flag = 1'b1;
    step();
    start_flag = 1'b0;
  endtask
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60 && !cmd_valid; i++) step();
    chk({tag, "_valid"}, 64'(cmd_valid), 64'd1);
  endtask
  task automatic do_burst(input string tag, input logic [2:0] d, input logic [24:0] a, input logic [8:0] l);
    wait_valid(tag);
    chk({tag, "_die"}, 64'(cmd_die), 64'(d));
    chk({tag, "_addr"}, 64'(cmd_addr), 64'(a));
    chk({tag, "_len"}, 64'(cmd_len), 64'(l));
    step();
    ctrl_done = 1'b1;
    step();
    ctrl_done = 1'b0;
  endtask
  initial begin
    int stall_valid, unstable;
    step();
    step();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_finish", 64'(read_finish), 0);
    chk("rst_error", 64'(error), 0);
    chk("rst_valid", 64'(cmd_valid), 0);
    chk("rst_fields", {cmd_die, cmd_addr, cmd_len, cmd_mode}, 0);
    system_reset_n = 1'b1;
    step();
    // two full 256-byte bursts, quad mode, latency 3
    start(32'h100, 32'h2FF, 2'd2);
    chk("t1_busy", 64'(busy), 1);
    step();
    chk("t1_lat_early", 64'(cmd_valid), 0);
    step();
    chk("t1_lat", 64'(cmd_valid), 1);
    chk("t1b1_fields", {cmd_die, cmd_addr, cmd_len, cmd_mode}, {3'd0, 25'h100, 9'd256, 2'd2});
    step();
    chk("t1_accepted", 64'(cmd_valid), 0);
    ctrl_done = 1'b1;
    step();
    ctrl_done = 1'b0;
    chk("t1_mid_finish", 64'(read_finish), 0);
    step();
    chk("t1b2_fields", {cmd_valid, cmd_die, cmd_addr, cmd_len, cmd_mode}, {1'b1, 3'd0, 25'h200, 9'd256, 2'd2});
    step();
    ctrl_done = 1'b1;
    step();
    ctrl_done = 1'b0;
    chk("t1_finish", 64'(read_finish), 1);
    step();
    chk("t1_finish_pulse", 64'(read_finish), 0);
    chk("t1_idle", 64'(busy), 0);
    // die-boundary crossing
    start(32'h01FF_FFF0, 32'h0200_000F, 2'd0);
    do_burst("t2b1", 3'd0, 25'h1FF_FFF0, 9'd16);
    chk("t2_mid_finish", 64'(read_finish), 0);
    do_burst("t2b2", 3'd1, 25'h0, 9'd16);
    chk("t2_finish", 64'(read_finish), 1);
    step();
    // fifo stall then back-pressure on cmd_ready
    fifo_free = '0;
    cmd_ready = 1'b0;
    start(32'h0, 32'hFF, 2'd1);
    stall_valid = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      stall_valid += int'(cmd_valid);
    end
    chk("t3_stall_valid", 64'(stall_valid), 0);
    fifo_free = 10'd40;
    step();
    chk("t3_fields", {cmd_valid, cmd_die, cmd_addr, cmd_len, cmd_mode}, {1'b1, 3'd0, 25'h0, 9'd40, 2'd1});
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      unstable += int'({cmd_valid, cmd_die, cmd_addr, cmd_len, cmd_mode} !== {1'b1, 3'd0, 25'h0, 9'd40, 2'd1});
    end
    chk("t3_hold_stable", 64'(unstable), 0);
    cmd_ready = 1'b1;
    fifo_free = 10'd512;
    step();
    chk("t3_accepted", 64'(cmd_valid), 0);
    abort = 1'b1;
    ctrl_done = 1'b1;
    step();
    ctrl_done = 1'b0;
    abort = 1'b0;
    chk("t3_abort_finish", 64'(read_finish), 1);
    step();
    // rejected requests
    start(32'h200, 32'h100, 2'd0);
    step();
    chk("t4a_error", {error, cmd_valid}, 2'b10);
    step();
    chk("t4a_after", {error, busy, cmd_valid}, 3'b000);
    start(32'h10, 32'h0400_0000, 2'd0);
    step();
    chk("t4b_error", {error, cmd_valid}, 2'b10);
    step();
    chk("t4b_after", {error, busy, cmd_valid}, 3'b000);
    start(32'h0, 32'h10, 2'd3);
    step();
    chk("t4c_error", {error, cmd_valid}, 2'b10);
    step();
    chk("t4c_after", {error, busy, cmd_valid}, 3'b000);
    // last byte of the last die, single-byte range
    start(32'h03FF_FFFF, 32'h03FF_FFFF, 2'd2);
    do_burst("t4d", 3'd1, 25'h1FF_FFFF, 9'd1);
    chk("t4d_finish", 64'(read_finish), 1);
    step();
    // abort held during the first burst of 1 KiB
    start(32'h0, 32'h3FF, 2'd2);
    wait_valid("t5");
    chk("t5_len", 64'(cmd_len), 256);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    ctrl_done = 1'b1;
    step();
    ctrl_done = 1'b0;
    chk("t5_finish", 64'(read_finish), 1);
    stall_valid = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      stall_valid += int'(cmd_valid);
    end
    chk("t5_no_more_cmd", {64'(stall_valid), busy}, 0);
    // reset during WAIT_DONE
    start(32'h0, 32'h3FF, 2'd2);
    wait_valid("t6");
    step();
    system_reset_n = 1'b0;
    step();
    system_reset_n = 1'b1;
    chk("t6_rst_outputs", {busy, read_finish, error, cmd_valid, cmd_die, cmd_addr, cmd_len, cmd_mode}, 0);
    ctrl_done = 1'b1;
    step();
    ctrl_done = 1'b0;
    stall_valid = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      stall_valid += int'(cmd_valid | busy | read_finish);
    end
    chk("t6_done_ignored", 64'(stall_valid), 0);
    start(32'h40, 32'h4F, 2'd0);
    do_burst("t6b", 3'd0, 25'h40, 9'd16);
    chk("t6_finish", 64'(read_finish), 1);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_flash_burst_reader.md
Name: spi_flash_burst_reader

Overview:
Parametrised successor to the single-byte flash read sequencer. It reads an inclusive byte range [start_addr, end_addr] spanning up to NUM_DIES stacked dies and splits it into bursts. Each burst is clipped to the die boundary, MAX_BURST and free FIFO space. It sits between the host control logic and the QSPI controller, which streams bytes into the shared FIFO. Burst completion is reported by the controller's done pulse.

Parameters:
ADDR_W, 32, global byte address width
DIE_ADDR_W, 25, log2 of die size in bytes (32 MiB per die)
NUM_DIES, 2, number of dies (1..8)
MAX_BURST, 256, maximum bytes per controller command (power of two)
LEN_W, 9, width of burst length field, must satisfy 2^LEN_W > MAX_BURST
FREE_W, 10, width of fifo_free

Ports:
system_clk  in  1  single clock
system_reset_n  in  1  reset, synchronous, active-low
start_flag  in  1  one-cycle start pulse, sampled only in IDLE
abort  in  1  stop after the current burst completes
start_addr  in  ADDR_W  first byte address
end_addr  in  ADDR_W  last byte address (inclusive)
mode  in  2  0 single, 1 dual, 2 quad, 3 reserved
busy  out  1  high in every state except IDLE
read_finish  out  1  one-cycle pulse when the range completes or is aborted
error  out  1  one-cycle pulse on a rejected request
cmd_valid  out  1  burst command valid
cmd_ready  in  1  controller accepts the command
cmd_die  out  3  target die index
cmd_addr  out  DIE_ADDR_W  die-local start address
cmd_len  out  LEN_W  burst length in bytes, range 1..MAX_BURST
cmd_mode  out  2  latched mode
ctrl_done  in  1  one-cycle pulse when the accepted burst is fully written to the FIFO
fifo_free  in  FREE_W  free FIFO entries

Behaviour:
- Reset: state IDLE; busy, read_finish, error and cmd_valid = 0; cmd_die, cmd_addr, cmd_len and cmd_mode = 0; internal curr_addr and remaining = 0. Reset applied mid-burst returns to IDLE on the next edge with no further commands issued.
- States: IDLE, CHECK, WAIT_SPACE, ISSUE, WAIT_DONE, DONE, ERR.
- IDLE: on start_flag, latch start_addr, end_addr and mode, then go to CHECK.
- CHECK, 1 cycle:
  - Go to ERR if any of: end_addr < start_addr, end_addr >= NUM_DIES << DIE_ADDR_W, or mode == 3.
  - Otherwise set remaining = end - start + 1, computed at ADDR_W+1 bits, and go to WAIT_SPACE.
- WAIT_SPACE:
  - If abort is set, go to DONE.
  - Else if fifo_free == 0, stay.
  - Else compute len = min(MAX_BURST, remaining, 2^DIE_ADDR_W - die_offset, fifo_free), register the command fields, and go to ISSUE.
- ISSUE:
  - cmd_valid = 1; all cmd_* fields stay stable until cmd_ready.
  - On the cycle cmd_valid && cmd_ready: curr_addr += len, remaining -= len, go to WAIT_DONE.
  - abort has no effect while in ISSUE.
- WAIT_DONE:
  - On ctrl_done: go to DONE if remaining == 0 or abort is set (or was set during the burst); otherwise go to WAIT_SPACE.
  - ctrl_done arriving in any other state is ignored.
- DONE: read_finish = 1 for one cycle, then IDLE.
- ERR: error = 1 for one cycle, then IDLE.
- Die mapping: cmd_die = curr_addr >> DIE_ADDR_W; cmd_addr = curr_addr[DIE_ADDR_W-1:0]. A burst never crosses a die boundary.
- Latency: start_flag to first cmd_valid is 3 cycles when fifo_free > 0 (IDLE, CHECK, WAIT_SPACE, ISSUE).
- Address wrap: end_addr = 2^ADDR_W - 1 is rejected by the range check, so curr_addr cannot overflow.
- Single-byte range (start == end): exactly one command with cmd_len = 1.
- start_flag is ignored while busy.

Decomposition:
- Shared package spi_flash_pkg holds:
  - mode encodings MODE_SINGLE, MODE_DUAL, MODE_QUAD, MODE_RSVD;
  - state enum values;
  - function die_of(addr).
- One sub-module: spi_burst_len_calc, a combinational four-way unsigned min with die-boundary distance. It is registered at the WAIT_SPACE to ISSUE edge.

Test Plan:
- Range 0x100..0x2FF, quad mode, fifo_free = 512, cmd_ready tied high → two bursts of 256 bytes at die 0, addresses 0x100 and 0x200, mode 2. One read_finish pulse, 1 cycle after the second ctrl_done.
- Range 0x01FFFFF0..0x0200000F → burst (die 0, 0x1FFFFF0, len 16), then (die 1, 0x0000000, len 16).
- fifo_free = 0 for 20 cycles, then 40 → no cmd_valid during the stall. First burst has len 40; cmd_valid held with stable fields while cmd_ready is low for 5 cycles.
- Invalid requests: end < start, end = 0x04000000, or mode = 3 → error pulse 2 cycles after start, no cmd_valid, busy low afterwards.
- abort asserted during the first burst of a 1 KiB range → no further command after ctrl_done, then read_finish pulse.
- system_reset_n low for 1 cycle during WAIT_DONE → all outputs 0 and IDLE next cycle. A later ctrl_done is ignored, and a new start works.
